id_imm_stage: RTL and testbench

//  Decode-stage front end, directly upstream of sign_extend.
//  - Accepts fetched instructions over a valid/ready handshake.
//  - Classifies each opcode into instr_type_t.
//  - Assembles the raw (unextended) immediate in the bit layout sign_extend expects.
//  - Registers the result in a 2-entry skid buffer. o_immediate/o_instr_type feed sign_extend directly.

---
 rtl/arriskv_pkg.sv | 27 ++
 rtl/id_imm_stage_imm_extract.sv | 57 +++++
 rtl/id_imm_stage.sv | 106 ++++++++++
 tb/tb_id_imm_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arriskv_pkg.sv
// Shared decode definitions: base-ISA opcodes and the instruction format
// classification consumed by sign_extend.
package arriskv_pkg;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // R is the all-zero encoding so a cleared entry reads back as R.
  typedef enum logic [2:0] {
    R  = 3'd0,
    I  = 3'd1,
    IJ = 3'd2,
    IL = 3'd3,
    S  = 3'd4,
    B  = 3'd5,
    U  = 3'd6,
    J  = 3'd7
  } instr_type_t;

endpackage

// File: rtl/id_imm_stage_imm_extract.sv
// Combinational opcode classifier and raw immediate assembler; bits above
// each format's immediate field are left zero for sign_extend to fill.
module imm_extract
  import arriskv_pkg::*;
#(
  parameter int wd_regs_p = 32
) (
  input  logic [31:0]          instr,
  output instr_type_t          instr_type,
  output logic [wd_regs_p-1:0] immediate,
  output logic                 illegal
);

  always_comb begin
    instr_type = R;
    immediate  = '0;
    illegal    = 1'b0;
    case (instr[6:0])
      OPC_OPIMM: begin
        instr_type      = I;
        immediate[11:0] = instr[31:20];
      end
      OPC_JALR: begin
        instr_type      = IJ;
        immediate[11:0] = instr[31:20];
      end
      OPC_LOAD: begin
        instr_type      = IL;
        immediate[11:0] = instr[31:20];
      end
      OPC_STORE: begin
        instr_type      = S;
        immediate[11:0] = {instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        instr_type      = B;
        immediate[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        instr_type      = U;
        immediate[19:0] = instr[31:12];
      end
      // J carries imm[20:1]; the consumer restores the implicit zero LSB.
      OPC_JAL: begin
        instr_type      = J;
        immediate[19:0] = {instr[31], instr[19:12], instr[20], instr[30:21]};
      end
      OPC_OP: begin
        instr_type = R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_imm_stage.sv
// Decode front end: classifies fetched instructions, assembles the raw
// immediate and holds results in a 2-entry skid buffer (head/tail + count).
module id_imm_stage
  import arriskv_pkg::*;
#(
  parameter int wd_regs_p = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_instr,
  input  logic [wd_regs_p-1:0] i_pc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [wd_regs_p-1:0] o_pc,
  output instr_type_t          o_instr_type,
  output logic [wd_regs_p-1:0] o_immediate,
  output logic [4:0]           o_rd,
  output logic [4:0]           o_rs1,
  output logic [4:0]           o_rs2,
  output logic                 o_illegal
);

  typedef struct packed {
    logic [wd_regs_p-1:0] pc;
    instr_type_t          instr_type;
    logic [wd_regs_p-1:0] imm;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 illegal;
  } entry_t;

  entry_t      head;
  entry_t      tail;
  entry_t      in_entry;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  instr_type_t dec_type;
  logic [wd_regs_p-1:0] dec_imm;
  logic        dec_illegal;

  imm_extract #(.wd_regs_p(wd_regs_p)) u_imm_extract (
    .instr      (i_instr),
    .instr_type (dec_type),
    .immediate  (dec_imm),
    .illegal    (dec_illegal)
  );

  assign in_entry = '{
    pc:         i_pc,
    instr_type: dec_type,
    imm:        dec_imm,
    rd:         i_instr[11:7],
    rs1:        i_instr[19:15],
    rs2:        i_instr[24:20],
    illegal:    dec_illegal
  };

  // Both handshake outputs come straight from the count register.
  assign o_ready = (count != 2'd2);
  assign o_valid = (count != 2'd0);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  // Push+pop only happens at count==1 (full blocks push, empty blocks pop),
  // so the new entry replaces the head directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else if (i_flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_entry;
          else               tail <= in_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          head <= in_entry;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_pc         = head.pc;
  assign o_instr_type = head.instr_type;
  assign o_immediate  = head.imm;
  assign o_rd         = head.rd;
  assign o_rs1        = head.rs1;
  assign o_rs2        = head.rs2;
  assign o_illegal    = head.illegal;

endmodule

// File: tb/tb_id_imm_stage.sv
// Self-checking bench for id_imm_stage: queue-based reference model checked
// every cycle, plus hand-computed literal expectations for key vectors.
module tb_id_imm_stage;
  import arriskv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  instr_type_t o_instr_type;
  logic [31:0] o_immediate;
  logic [4:0]  o_rd;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic        o_illegal;

  int checks;
  int failures;

  id_imm_stage #(.wd_regs_p(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (i_flush),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_instr      (i_instr),
    .i_pc         (i_pc),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_pc         (o_pc),
    .o_instr_type (o_instr_type),
    .o_immediate  (o_immediate),
    .o_rd         (o_rd),
    .o_rs1        (o_rs1),
    .o_rs2        (o_rs2),
    .o_illegal    (o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } tb_entry_t;

  tb_entry_t model_q[$];

  // Reference decode: build the architectural (sign-extended) immediate,
  // then keep only the field sign_extend expects.
  function automatic instr_type_t ref_type(input logic [31:0] ins);
    case (ins[6:0])
      7'h13:         return I;
      7'h67:         return IJ;
      7'h03:         return IL;
      7'h23:         return S;
      7'h63:         return B;
      7'h37, 7'h17:  return U;
      7'h6F:         return J;
      default:       return R;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] ins);
    return !(ins[6:0] inside {7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33});
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int signed v;
    case (ref_type(ins))
      I, IJ, IL: begin
        v = $signed(ins) >>> 20;
        return 32'(v) & 32'hFFF;
      end
      S: begin
        v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
        return 32'(v) & 32'hFFF;
      end
      B: begin
        v = (($signed(ins) >>> 31) * 4096) + int'(ins[7]) * 2048
            + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        return 32'(v) & 32'h1FFF;
      end
      U: return 32'(ins >> 12);
      J: begin
        v = (($signed(ins) >>> 31) * 1048576) + int'(ins[19:12]) * 4096
            + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        return 32'(v >>> 1) & 32'hFFFFF;
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edge as the DUT, using only its own occupancy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else if (i_flush) begin
      model_q.delete();
    end else begin
      automatic bit do_push = i_valid && (model_q.size() < 2);
      automatic bit do_pop  = i_ready && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: i_pc, instr: i_instr});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc_valid", 32'(o_valid), 32'(model_q.size() != 0));
      checkOutput("cyc_ready", 32'(o_ready), 32'(model_q.size() < 2));
      if (model_q.size() != 0) begin
        checkOutput("cyc_pc",      o_pc,                 model_q[0].pc);
        checkOutput("cyc_type",    32'(o_instr_type),    32'(ref_type(model_q[0].instr)));
        checkOutput("cyc_imm",     o_immediate,          ref_imm(model_q[0].instr));
        checkOutput("cyc_rd",      32'(o_rd),            32'(model_q[0].instr[11:7]));
        checkOutput("cyc_rs1",     32'(o_rs1),           32'(model_q[0].instr[19:15]));
        checkOutput("cyc_rs2",     32'(o_rs2),           32'(model_q[0].instr[24:20]));
        checkOutput("cyc_illegal", 32'(o_illegal),       32'(ref_illegal(model_q[0].instr)));
      end
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    i_valid = v;
    i_instr = ins;
    i_pc    = pc;
    i_ready = rdy;
    i_flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"},   32'(o_valid),      32'd0);
    checkOutput({tag, "_ready"},   32'(o_ready),      32'd1);
    checkOutput({tag, "_pc"},      o_pc,              32'd0);
    checkOutput({tag, "_imm"},     o_immediate,       32'd0);
    checkOutput({tag, "_rd"},      32'(o_rd),         32'd0);
    checkOutput({tag, "_rs1"},     32'(o_rs1),        32'd0);
    checkOutput({tag, "_rs2"},     32'(o_rs2),        32'd0);
    checkOutput({tag, "_illegal"}, 32'(o_illegal),    32'd0);
    checkOutput({tag, "_type"},    32'(o_instr_type), 32'(R));
  endtask

  logic [31:0] mix_tab [6] = '{32'hFFDFF0EF, 32'h00008067, 32'h00412083,
                                32'h00001517, 32'h002081B3, 32'h0000000B};

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    i_flush  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_instr  = '0;
    i_pc     = '0;
    #2;
    checkReset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1, x0, -1
    applyStimulus(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    checkOutput("addi_valid", 32'(o_valid),      32'd1);
    checkOutput("addi_type",  32'(o_instr_type), 32'(I));
    checkOutput("addi_imm",   o_immediate,       32'h00000FFF);
    checkOutput("addi_rd",    32'(o_rd),         32'd1);
    checkOutput("addi_ill",   32'(o_illegal),    32'd0);

    applyStimulus(1'b1, 32'hFE112E23, 32'h104, 1'b1, 1'b0);
    checkOutput("sw_type", 32'(o_instr_type), 32'(S));
    checkOutput("sw_imm",  o_immediate,       32'h00000FFC);
    checkOutput("sw_rs1",  32'(o_rs1),        32'd2);
    checkOutput("sw_rs2",  32'(o_rs2),        32'd1);

    applyStimulus(1'b1, 32'hFE000CE3, 32'h108, 1'b1, 1'b0);
    checkOutput("beq_type", 32'(o_instr_type), 32'(B));
    checkOutput("beq_imm",  o_immediate,       32'h00001FF8);

    applyStimulus(1'b1, 32'h123452B7, 32'h10C, 1'b1, 1'b0);
    checkOutput("lui_type", 32'(o_instr_type), 32'(U));
    checkOutput("lui_imm",  o_immediate,       32'h00012345);

    applyStimulus(1'b1, 32'hFFDFF0EF, 32'h110, 1'b1, 1'b0);
    checkOutput("jal_type", 32'(o_instr_type), 32'(J));
    checkOutput("jal_imm",  o_immediate,       32'h000FFFFE);

    applyStimulus(1'b1, 32'h0000007F, 32'h114, 1'b1, 1'b0);
    checkOutput("ill_flag", 32'(o_illegal),    32'd1);
    checkOutput("ill_type", 32'(o_instr_type), 32'(R));
    checkOutput("ill_imm",  o_immediate,       32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain1_valid", 32'(o_valid), 32'd0);

    // Backpressure: A, B fill the buffer, C is held until i_ready rises.
    applyStimulus(1'b1, 32'h00A00513, 32'h200, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00B00593, 32'h204, 1'b0, 1'b0);
    checkOutput("full_ready", 32'(o_ready), 32'd0);
    checkOutput("full_head",  o_pc,         32'h200);
    applyStimulus(1'b1, 32'h00C00613, 32'h208, 1'b0, 1'b0);
    checkOutput("held_head", o_pc, 32'h200);
    applyStimulus(1'b1, 32'h00C00613, 32'h208, 1'b1, 1'b0);
    checkOutput("bp_pc_b", o_pc, 32'h204);
    applyStimulus(1'b1, 32'h00C00613, 32'h208, 1'b1, 1'b0);
    checkOutput("bp_pc_c",  o_pc,        32'h208);
    checkOutput("bp_imm_c", o_immediate, 32'h00C);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain2_valid", 32'(o_valid), 32'd0);

    // Flush while full, with an instruction presented alongside.
    applyStimulus(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00200093, 32'h304, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00300093, 32'h308, 1'b0, 1'b1);
    checkOutput("flush_valid", 32'(o_valid), 32'd0);
    checkOutput("flush_ready", 32'(o_ready), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_after", 32'(o_valid), 32'd0);

    // Steady streaming at count==1.
    applyStimulus(1'b1, 32'h00000013, 32'h400, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 32'h00000013 | (32'(k) << 20), 32'h400 + 32'(4 * k), 1'b1, 1'b0);
      checkOutput("stream_ready", 32'(o_ready), 32'd1);
      checkOutput("stream_valid", 32'(o_valid), 32'd1);
      checkOutput("stream_pc",    o_pc,         32'h400 + 32'(4 * k));
      checkOutput("stream_imm",   o_immediate,  32'(k));
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Mixed formats with alternating backpressure.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, mix_tab[k], 32'h500 + 32'(4 * k), 1'(k % 2), 1'b0);
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("mix_drained", 32'(o_valid), 32'd0);

    // Asynchronous reset while full.
    applyStimulus(1'b1, 32'hFFF00093, 32'h600, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFE112E23, 32'h604, 1'b0, 1'b0);
    checkOutput("prerst_ready", 32'(o_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkReset("arst");
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("postrst_valid", 32'(o_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
